// File: rtl/axis_bram_reader.sv
// axis_bram_reader: circular BRAM port-A reader feeding an AXI4-Stream master through a 2-entry skid FIFO
// Optional macro AXIS_BRAM_READER_TLAST_EN adds m_axis_tlast, asserted on the word read from the wrap address.
// Ports:
//   aclk, aresetn         clock, synchronous active-low reset
//   cfg_data              last address of the circular region (inclusive)
//   sts_data              next address to be issued to the BRAM
//   m_axis_*              stream master (tdata, tvalid, tready, optional tlast)
//   a_bram_*              BRAM port A (clk, rst, en, addr, rdata with 1-cycle latency)
module axis_bram_reader #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int BRAM_DATA_WIDTH  = 32,
  parameter int BRAM_ADDR_WIDTH  = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [BRAM_ADDR_WIDTH-1:0]  cfg_data,
  output logic [BRAM_ADDR_WIDTH-1:0]  sts_data,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
`ifdef AXIS_BRAM_READER_TLAST_EN
  output logic                        m_axis_tlast,
`endif
  input  logic                        m_axis_tready,
  output logic                        a_bram_clk,
  output logic                        a_bram_rst,
  output logic                        a_bram_en,
  output logic [BRAM_ADDR_WIDTH-1:0]  a_bram_addr,
  input  logic [BRAM_DATA_WIDTH-1:0]  a_bram_rdata
);
`ifdef AXIS_BRAM_READER_TLAST_EN
  localparam int EW = BRAM_DATA_WIDTH + 1;
`else
  localparam int EW = BRAM_DATA_WIDTH;
`endif
  logic [BRAM_ADDR_WIDTH-1:0] r_addr;
  logic                       r_inflight;
  logic [1:0]                 r_cnt;
  logic [EW-1:0]              r_d0, r_d1;
  logic                       w_pop, w_issue, w_wrap;
  logic [1:0]                 w_base;
  logic [EW-1:0]              w_in;
  assign w_pop    = (r_cnt != 2'd0) & m_axis_tready;
  // occupancy left after this cycle's pop; the capture slot and the issue budget both derive from it
  assign w_base   = r_cnt - {1'b0, w_pop};
  assign w_issue  = aresetn & ((w_base + {1'b0, r_inflight}) < 2'd2);
  // exact equality, so a bound lowered below the counter lets it run up and wrap modulo 2^W first
  assign w_wrap   = r_addr == cfg_data;
  assign a_bram_clk    = aclk;
  assign a_bram_rst    = ~aresetn;
  assign a_bram_en     = w_issue;
  assign a_bram_addr   = r_addr;
  assign sts_data      = r_addr;
  assign m_axis_tvalid = r_cnt != 2'd0;
  assign m_axis_tdata  = r_d0[BRAM_DATA_WIDTH-1:0];
`ifdef AXIS_BRAM_READER_TLAST_EN
  logic r_if_last;
  assign w_in         = {r_if_last, a_bram_rdata};
  assign m_axis_tlast = m_axis_tvalid & r_d0[EW-1];
  always_ff @(posedge aclk)
    if (w_issue) r_if_last <= w_wrap;
`else
  assign w_in = a_bram_rdata;
`endif
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_addr     <= '0;
      r_inflight <= 1'b0;
      r_cnt      <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) r_addr <= w_wrap ? '0 : r_addr + 1'b1;
      r_cnt      <= w_base + {1'b0, r_inflight};
    end
  end
  // payload needs no reset: tvalid and tlast are qualified by the occupancy count
  always_ff @(posedge aclk) begin
    r_d0 <= (r_inflight && w_base == 2'd0) ? w_in : w_pop ? r_d1 : r_d0;
    r_d1 <= (r_inflight && w_base != 2'd0) ? w_in : r_d1;
  end
endmodule

// File: tb/tb_axis_bram_reader.sv
// tb_axis_bram_reader: scoreboard bench for axis_bram_reader with a 1-cycle BRAM model
module tb_axis_bram_reader;
  localparam int AW = 10;
  localparam int DW = 32;
  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [AW-1:0] cfg_data = 10'd3;
  logic [AW-1:0] sts_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          a_bram_clk, a_bram_rst, a_bram_en;
  logic [AW-1:0] a_bram_addr;
  logic [DW-1:0] a_bram_rdata = '0;
  logic [DW-1:0] mem [1024];
  logic [DW:0]   q [$];
  logic [DW:0]   e;
  logic [DW-1:0] p_data;
  logic [AW-1:0] m_addr = '0;
  logic          fire, p_hold = 1'b0, saw_top = 1'b0;
  int            tests = 0, fails = 0, beats = 0, outst = 0, b0;
`ifdef AXIS_BRAM_READER_TLAST_EN
  logic          m_axis_tlast;
`endif
  axis_bram_reader dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_data(cfg_data), .sts_data(sts_data),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
`ifdef AXIS_BRAM_READER_TLAST_EN
    .m_axis_tlast(m_axis_tlast),
`endif
    .m_axis_tready(m_axis_tready), .a_bram_clk(a_bram_clk), .a_bram_rst(a_bram_rst),
    .a_bram_en(a_bram_en), .a_bram_addr(a_bram_addr), .a_bram_rdata(a_bram_rdata)
  );
  always #5 aclk = ~aclk;
  always @(posedge aclk) if (a_bram_en) a_bram_rdata <= mem[a_bram_addr];
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge aclk);
    #1;
  endtask
  task automatic do_reset(input logic [AW-1:0] c);
    aresetn = 1'b0;
    cfg_data = c;
    repeat (2) step();
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_sts", sts_data, '0);
    check("rst_en", a_bram_en, 1'b0);
    aresetn = 1'b1;
  endtask
  always @(negedge aclk) begin
    if (!aresetn) begin
      q.delete();
      m_addr = '0;
      outst = 0;
      p_hold = 1'b0;
    end else begin
      fire = m_axis_tvalid & m_axis_tready;
      check("en_rule", a_bram_en, (outst - int'(fire)) < 2);
      if (p_hold) begin
        check("hold_tvalid", m_axis_tvalid, 1'b1);
        check("hold_tdata", m_axis_tdata, p_data);
      end
      if (fire) begin
        beats++;
        check("beat_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("tdata", m_axis_tdata, e[DW-1:0]);
`ifdef AXIS_BRAM_READER_TLAST_EN
          check("tlast", m_axis_tlast, e[DW]);
`endif
        end
      end
      if (a_bram_en) begin
        check("addr", a_bram_addr, m_addr);
        if (m_addr == 10'd1023) saw_top = 1'b1;
        q.push_back({m_addr == cfg_data, mem[m_addr]});
        m_addr = (m_addr == cfg_data) ? '0 : m_addr + 1'b1;
      end
      outst = outst + int'(a_bram_en) - int'(fire);
      p_hold = m_axis_tvalid & ~m_axis_tready;
      p_data = m_axis_tdata;
    end
  end
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = DW'(i + 'h100);
    m_axis_tready = 1'b1;
    do_reset(10'd3);
    step();
    check("tvalid_after_issue", m_axis_tvalid, 1'b0);
    step();
    check("first_tvalid", m_axis_tvalid, 1'b1);
    check("first_tdata", m_axis_tdata, 32'h100);
    b0 = beats;
    repeat (16) step();
    check("throughput", beats - b0, 16);
    do_reset(10'd3);
    b0 = beats;
    for (int i = 0; i < 20 && beats - b0 < 2; i++) step();
    check("two_beats_seen", beats - b0, 2);
    m_axis_tready = 1'b0;
    repeat (5) begin
      step();
      check("bp_tvalid", m_axis_tvalid, 1'b1);
      check("bp_tdata", m_axis_tdata, 32'h102);
    end
    check("bp_en_off", a_bram_en, 1'b0);
    m_axis_tready = 1'b1;
    b0 = beats;
    repeat (6) step();
    check("resume_no_bubble", beats - b0, 6);
    do_reset(10'd1023);
    b0 = beats;
    repeat (2000) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      step();
    end
    m_axis_tready = 1'b1;
    repeat (4) step();
    check("rand_progress", beats - b0 > 500, 1'b1);
    do_reset(10'd7);
    for (int i = 0; i < 20 && sts_data != 10'd5; i++) step();
    check("reach_5", sts_data, 10'd5);
    cfg_data = 10'd2;
    saw_top = 1'b0;
    repeat (1040) step();
    check("wrap_via_top", saw_top, 1'b1);
    check("new_bound", sts_data <= 10'd2, 1'b1);
    do_reset(10'd3);
    repeat (3) step();
    m_axis_tready = 1'b0;
    repeat (4) step();
    check("full_en_off", a_bram_en, 1'b0);
    check("full_tvalid", m_axis_tvalid, 1'b1);
    aresetn = 1'b0;
    step();
    aresetn = 1'b1;
    check("midrst_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_sts", sts_data, '0);
    m_axis_tready = 1'b1;
    repeat (2) step();
    check("restart_tvalid", m_axis_tvalid, 1'b1);
    check("restart_tdata", m_axis_tdata, 32'h100);
    do_reset(10'd3);
    repeat (300) begin
      m_axis_tready = 1'($urandom_range(0, 1));
      step();
    end
    m_axis_tready = 1'b1;
    repeat (4) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axis_bram_reader.md
Name: axis_bram_reader

Overview:
Port-A BRAM reader paired with the stream-to-BRAM writer. It reads a circular buffer from address 0 to cfg_data inclusive, wraps, and repeats. Read data goes out on an AXI4-Stream master with full backpressure support. Typical use is playback of waveform/table data that the writer (or PS) has loaded into the shared dual-port BRAM.

Parameters:
AXIS_TDATA_WIDTH, 32, stream data width; must equal BRAM_DATA_WIDTH
BRAM_DATA_WIDTH, 32, BRAM read data width
BRAM_ADDR_WIDTH, 10, BRAM word address width

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
cfg_data  in  BRAM_ADDR_WIDTH  last address of circular region (inclusive)
sts_data  out  BRAM_ADDR_WIDTH  next address to be issued to BRAM
m_axis_tdata  out  AXIS_TDATA_WIDTH  stream data
m_axis_tvalid  out  1  stream valid
m_axis_tready  in  1  stream ready
m_axis_tlast  out  1  only with AXIS_BRAM_READER_TLAST_EN
a_bram_clk  out  1  = aclk
a_bram_rst  out  1  = ~aresetn
a_bram_en  out  1  read enable
a_bram_addr  out  BRAM_ADDR_WIDTH  read address
a_bram_rdata  in  BRAM_DATA_WIDTH  read data, valid 1 cycle after en

Behaviour:
- Reset is decided as: aresetn synchronous, active-low; clock aclk.
- Reset values: addr counter 0, output FIFO empty, m_axis_tvalid 0, m_axis_tlast 0, sts_data 0, in-flight flag 0.
- BRAM latency is fixed at 1 cycle. A word requested with a_bram_en=1 at edge N is captured at edge N+1.
- Output stage is a 2-entry FIFO (skid buffer). m_axis_tvalid = FIFO not empty. m_axis_tdata/tlast = head entry.
- Issue rule: a_bram_en = aresetn & (FIFO occupancy + in-flight + 0 after pop this cycle) < 2.
  - Occupancy after this cycle's pop is counted, so read issue never exceeds FIFO capacity.
  - a_bram_addr = addr counter (combinational from register).
- On issue, the addr counter advances to 0 if counter == cfg_data, else counter+1. This is width-modular, so 2^W-1 wraps to 0.
- cfg_data is sampled at each issue. If cfg_data is lowered below the current counter, the counter continues upward, wraps at 2^W-1, then obeys the new bound. No words are dropped or duplicated.
- cfg_data = 0: address 0 is read every issue.
- Throughput: with m_axis_tready held 1, one word per cycle. The first tvalid appears 2 edges after reset release (issue, capture).
- Backpressure: with tready=0 the FIFO fills to 2, then a_bram_en=0. Data is held stable while tvalid=1 & tready=0 (AXI rule). After tready returns, no bubble occurs beyond the refill needed.
- Simultaneous capture and pop: occupancy is unchanged and ordering is preserved.
- Reset mid-operation: FIFO and in-flight are discarded, and tvalid drops at the reset edge. Read data arriving after reset is ignored.
- sts_data = addr counter.

Optional Feature:
AXIS_BRAM_READER_TLAST_EN:
- Defined: adds port m_axis_tlast. Each issued address carries a flag (addr == cfg_data at issue) through the in-flight register and FIFO alongside data. tlast = 1 on the word read from the wrap address.
- Not defined: no tlast port, and no extra flag storage.

Test Plan:
- BRAM preloaded mem[i]=i+0x100, cfg_data=3, tready=1 from reset -> stream 0x100,0x101,0x102,0x103,0x100,... one per cycle; first tvalid 2 cycles after reset release.
- Same setup, tready low for 5 cycles after 2nd beat -> a_bram_en deasserts after FIFO holds 2 words; tdata stable at 0x102; resume gives 0x102,0x103,0x100 with no loss or duplication.
- Random tready (50%) for 2000 cycles, cfg_data=1023 -> output equals sequence mem[k mod 1024] exactly; a_bram_en never issues with occupancy+in-flight=2.
- cfg_data changed 7->2 while counter=5 -> addresses 5,6,...,1023,0,1,2,0,...; stream matches.
- aresetn pulsed low 1 cycle mid-stream with FIFO full -> tvalid 0 next cycle; restart from mem[0]; sts_data=0 during reset.
- TLAST_EN defined, cfg_data=3 -> tlast=1 exactly on beats of mem[3]; under random tready tlast stays aligned to the 0x103 beats.
